// File: rtl/key_press_conditioner.sv
// Key input conditioner: per-key 2-flop sync, debounce FSM and press pulse.
// Optional re-press lockout when KEY_COND_HOLDOFF_EN is defined.
module key_press_conditioner #(
  parameter int NUM_KEYS        = 2,
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int ACTIVE_LOW      = 1,
  parameter int HOLDOFF_CYCLES  = 8
) (
  input  logic                Clock,
  input  logic                Reset,
  input  logic [NUM_KEYS-1:0] key_raw,
  input  logic                enable,
  output logic [NUM_KEYS-1:0] held,
  output logic [NUM_KEYS-1:0] press
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);

  typedef enum logic [1:0] {
    RELEASED,
    PRESS_PEND,
    PRESSED,
    RELEASE_PEND
  } state_t;

  logic [NUM_KEYS-1:0] key_p0;
  logic [NUM_KEYS-1:0] sync_p1;
  logic [NUM_KEYS-1:0] sync_p2;

  assign key_p0 = (ACTIVE_LOW != 0) ? ~key_raw : key_raw;

  // Stage p1/p2: synchronizer; reset loads the released level
  always_ff @(posedge Clock) begin
    if (Reset) begin
      sync_p1 <= '0;
      sync_p2 <= '0;
    end else begin
      sync_p1 <= key_p0;
      sync_p2 <= sync_p1;
    end
  end

`ifndef KEY_COND_HOLDOFF_EN
  logic unused_holdoff;
  assign unused_holdoff = (HOLDOFF_CYCLES != 0);
`endif

  for (genvar k = 0; k < NUM_KEYS; k++) begin : g_key
    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          accept;
    logic          allow;
    logic          held_q;
    logic          acc_p3;
    logic          press_p4;

    always_ff @(posedge Clock) begin
      if (Reset) begin
        state_q <= RELEASED;
        cnt_q   <= '0;
      end else begin
        state_q <= state_d;
        cnt_q   <= cnt_d;
      end
    end

    always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      accept  = 1'b0;
      case (state_q)
        RELEASED: begin
          if (sync_p2[k]) begin
            state_d = PRESS_PEND;
            cnt_d   = CW'(1);
          end
        end
        PRESS_PEND: begin
          if (!sync_p2[k]) begin
            state_d = RELEASED;
            cnt_d   = '0;
          end else if (cnt_q == CW'(DEBOUNCE_CYCLES)) begin
            state_d = PRESSED;
            cnt_d   = '0;
            accept  = 1'b1;
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end
        PRESSED: begin
          if (!sync_p2[k]) begin
            state_d = RELEASE_PEND;
            cnt_d   = CW'(1);
          end
        end
        RELEASE_PEND: begin
          if (sync_p2[k]) begin
            state_d = PRESSED;
            cnt_d   = '0;
          end else if (cnt_q == CW'(DEBOUNCE_CYCLES)) begin
            state_d = RELEASED;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end
        default: begin
          state_d = RELEASED;
          cnt_d   = '0;
        end
      endcase
    end

`ifdef KEY_COND_HOLDOFF_EN
    localparam int HW = $clog2(HOLDOFF_CYCLES + 1);
    logic [HW-1:0] hold_q;

    // Lockout window starts on the cycle the pulse is visible
    always_ff @(posedge Clock) begin
      if (Reset) begin
        hold_q <= '0;
      end else if (press_p4) begin
        hold_q <= HW'(HOLDOFF_CYCLES);
      end else if (hold_q != '0) begin
        hold_q <= hold_q - HW'(1);
      end
    end

    assign allow = (hold_q == '0);
`else
    assign allow = 1'b1;
`endif

    // Stage p3/p4: accept qualified on the transition edge, then pulse
    always_ff @(posedge Clock) begin
      if (Reset) begin
        held_q   <= 1'b0;
        acc_p3   <= 1'b0;
        press_p4 <= 1'b0;
      end else begin
        held_q   <= (state_q == PRESSED) || (state_q == RELEASE_PEND);
        acc_p3   <= accept & enable & allow;
        press_p4 <= acc_p3;
      end
    end

    assign held[k]  = held_q;
    assign press[k] = press_p4;
  end

endmodule
